// File: rtl/mux_arbiter_if.sv
// Handshake bundle between four requesters, the arbiter and the downstream consumer.
interface mux_arbiter_if #(
  parameter int unsigned INPUT_LENGTH = 32
);
  logic [3:0]              req_valid;
  logic [3:0]              req_lock;
  logic [3:0]              req_ready;
  logic [INPUT_LENGTH-1:0] a_data;
  logic [INPUT_LENGTH-1:0] b_data;
  logic [INPUT_LENGTH-1:0] c_data;
  logic [INPUT_LENGTH-1:0] d_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [INPUT_LENGTH-1:0] out_data;
  logic [1:0]              out_src;

  modport master (
    output req_valid, req_lock, a_data, b_data, c_data, d_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_lock, a_data, b_data, c_data, d_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin four-way arbiter with optional burst locking feeding a single-entry
// registered output stage.
module mux_arbiter #(
  parameter int unsigned INPUT_LENGTH = 32,
  parameter int unsigned MAX_BURST    = 8
) (
  input logic          clk,
  input logic          rst,
  mux_arbiter_if.slave bus
);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {ARB, LOCKED} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [1:0]              owner_q, owner_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic                    out_valid_q, out_valid_d;
  logic [INPUT_LENGTH-1:0] out_data_q, out_data_d;
  logic [1:0]              out_src_q, out_src_d;

  logic [1:0]              grant;
  logic                    grant_vld;
  logic                    slot_free;
  logic                    accept;
  logic [INPUT_LENGTH-1:0] mux_data;

  always_comb begin
    grant     = ptr_q;
    grant_vld = 1'b0;
    if (state_q == LOCKED) begin
      grant     = owner_q;
      grant_vld = bus.req_valid[owner_q];
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!grant_vld && bus.req_valid[ptr_q + 2'(i)]) begin
          grant     = ptr_q + 2'(i);
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Reset gates acceptance so nothing is taken in a reset cycle.
  assign slot_free     = !out_valid_q || bus.out_ready;
  assign accept        = grant_vld && slot_free && !rst;
  assign bus.req_ready = accept ? (4'b0001 << grant) : '0;

  always_comb begin
    mux_data = bus.a_data;
    case (grant)
      2'd0:    mux_data = bus.a_data;
      2'd1:    mux_data = bus.b_data;
      2'd2:    mux_data = bus.c_data;
      default: mux_data = bus.d_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + CW'(1);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_src_d   = grant;
      if (state_q == ARB) begin
        if (bus.req_lock[grant] && (MAX_BURST > 1)) begin
          state_d = LOCKED;
          owner_d = grant;
          cnt_d   = CW'(1);
        end else begin
          ptr_d = grant + 2'd1;
        end
      end else begin
        // Releasing beat moves the owner to lowest priority.
        if (!bus.req_lock[owner_q] || (cnt_inc == CW'(MAX_BURST))) begin
          state_d = ARB;
          ptr_d   = owner_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// Scenario bench for mux_arbiter: expected beats queued at acceptance, compared on transfer.
module tb_mux_arbiter;
  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] l;
    logic       o;
    logic [3:0] r;
  } step_t;

  logic [W+1:0] exp_q [$];
  logic [W+1:0] exp;

  mux_arbiter_if #(.INPUT_LENGTH(W)) bus ();

  mux_arbiter #(.INPUT_LENGTH(W), .MAX_BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+1:0] beat_of(input logic [3:0] oh);
    case (oh)
      4'b0001: return {2'd0, 32'h0000_0003};
      4'b0010: return {2'd1, 32'h0000_00ff};
      4'b0100: return {2'd2, 32'h0000_000f};
      default: return {2'd3, 32'h0000_00ee};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_lock  = 4'b0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (bus.req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_ready got %b want 0000", bus.req_ready);
      end
      step();
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_src !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_out got valid=%b data=%h src=%0d want 0/0/0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    rst = 1'b0;
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    step_t s [6];
    s = '{'{4'b1111, 4'b0000, 1'b1, 4'b0001},
          '{4'b1111, 4'b0000, 1'b1, 4'b0010},
          '{4'b1111, 4'b0000, 1'b1, 4'b0100},
          '{4'b1111, 4'b0000, 1'b1, 4'b1000},
          '{4'b1111, 4'b0000, 1'b1, 4'b0001},
          '{4'b0000, 4'b0000, 1'b1, 4'b0000}};
    foreach (s[k]) begin
      bus.req_valid = s[k].v; bus.req_lock = s[k].l; bus.out_ready = s[k].o;
      #1;
      vectors++;
      if (bus.req_ready !== s[k].r) begin
        miscompares++;
        $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready, s[k].r);
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rr_beat[%0d] got unexpected src=%0d want none", k, bus.out_src);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.out_src, bus.out_data} !== exp) begin
            miscompares++;
            $display("FAIL rr_beat[%0d] got src=%0d data=%h want src=%0d data=%h",
                     k, bus.out_src, bus.out_data, exp[W+1:W], exp[W-1:0]);
          end
        end
      end
      if (s[k].r != 4'b0000) exp_q.push_back(beat_of(s[k].r));
      step();
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rr_end got valid=%b pending=%0d want 0/0", bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    step_t s [5];
    s = '{'{4'b0100, 4'b0000, 1'b0, 4'b0100},
          '{4'b0100, 4'b0000, 1'b0, 4'b0000},
          '{4'b0100, 4'b0000, 1'b0, 4'b0000},
          '{4'b0100, 4'b0000, 1'b0, 4'b0000},
          '{4'b0000, 4'b0000, 1'b1, 4'b0000}};
    foreach (s[k]) begin
      bus.req_valid = s[k].v; bus.req_lock = s[k].l; bus.out_ready = s[k].o;
      #1;
      vectors++;
      if (bus.req_ready !== s[k].r) begin
        miscompares++;
        $display("FAIL bp_ready[%0d] got %b want %b", k, bus.req_ready, s[k].r);
      end
      if (k >= 1 && k <= 3) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2 || bus.out_data !== 32'h0f) begin
          miscompares++;
          $display("FAIL bp_hold[%0d] got valid=%b src=%0d data=%h want 1/2/0000000f",
                   k, bus.out_valid, bus.out_src, bus.out_data);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_beat[%0d] got unexpected src=%0d want none", k, bus.out_src);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.out_src, bus.out_data} !== exp) begin
            miscompares++;
            $display("FAIL bp_beat[%0d] got src=%0d data=%h want src=%0d data=%h",
                     k, bus.out_src, bus.out_data, exp[W+1:W], exp[W-1:0]);
          end
        end
      end
      if (s[k].r != 4'b0000) exp_q.push_back(beat_of(s[k].r));
      step();
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_end got valid=%b pending=%0d want 0/0", bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_lock_burst();
    step_t s [8];
    s = '{'{4'b0001, 4'b0000, 1'b1, 4'b0001},
          '{4'b1111, 4'b0010, 1'b1, 4'b0010},
          '{4'b1111, 4'b0010, 1'b1, 4'b0010},
          '{4'b1111, 4'b0010, 1'b1, 4'b0010},
          '{4'b1111, 4'b0010, 1'b1, 4'b0010},
          '{4'b1111, 4'b0000, 1'b1, 4'b0010},
          '{4'b1111, 4'b0000, 1'b1, 4'b0100},
          '{4'b0000, 4'b0000, 1'b1, 4'b0000}};
    foreach (s[k]) begin
      bus.req_valid = s[k].v; bus.req_lock = s[k].l; bus.out_ready = s[k].o;
      #1;
      vectors++;
      if (bus.req_ready !== s[k].r) begin
        miscompares++;
        $display("FAIL lock_ready[%0d] got %b want %b", k, bus.req_ready, s[k].r);
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL lock_beat[%0d] got unexpected src=%0d want none", k, bus.out_src);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.out_src, bus.out_data} !== exp) begin
            miscompares++;
            $display("FAIL lock_beat[%0d] got src=%0d data=%h want src=%0d data=%h",
                     k, bus.out_src, bus.out_data, exp[W+1:W], exp[W-1:0]);
          end
        end
      end
      if (s[k].r != 4'b0000) exp_q.push_back(beat_of(s[k].r));
      step();
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL lock_end got valid=%b pending=%0d want 0/0", bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_forced_release();
    step_t s [10];
    for (int i = 0; i < 8; i++) s[i] = '{4'b1111, 4'b1000, 1'b1, 4'b1000};
    s[8] = '{4'b1111, 4'b1000, 1'b1, 4'b0001};
    s[9] = '{4'b0000, 4'b0000, 1'b1, 4'b0000};
    foreach (s[k]) begin
      bus.req_valid = s[k].v; bus.req_lock = s[k].l; bus.out_ready = s[k].o;
      #1;
      vectors++;
      if (bus.req_ready !== s[k].r) begin
        miscompares++;
        $display("FAIL max_ready[%0d] got %b want %b", k, bus.req_ready, s[k].r);
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL max_beat[%0d] got unexpected src=%0d want none", k, bus.out_src);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.out_src, bus.out_data} !== exp) begin
            miscompares++;
            $display("FAIL max_beat[%0d] got src=%0d data=%h want src=%0d data=%h",
                     k, bus.out_src, bus.out_data, exp[W+1:W], exp[W-1:0]);
          end
        end
      end
      if (s[k].r != 4'b0000) exp_q.push_back(beat_of(s[k].r));
      step();
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL max_end got valid=%b pending=%0d want 0/0", bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_owner_bubble();
    step_t s [8];
    s = '{'{4'b0001, 4'b0001, 1'b1, 4'b0001},
          '{4'b0011, 4'b0001, 1'b1, 4'b0001},
          '{4'b0010, 4'b0001, 1'b1, 4'b0000},
          '{4'b0010, 4'b0001, 1'b1, 4'b0000},
          '{4'b0011, 4'b0001, 1'b1, 4'b0001},
          '{4'b0011, 4'b0000, 1'b1, 4'b0001},
          '{4'b0010, 4'b0000, 1'b1, 4'b0010},
          '{4'b0000, 4'b0000, 1'b1, 4'b0000}};
    foreach (s[k]) begin
      bus.req_valid = s[k].v; bus.req_lock = s[k].l; bus.out_ready = s[k].o;
      #1;
      vectors++;
      if (bus.req_ready !== s[k].r) begin
        miscompares++;
        $display("FAIL bubble_ready[%0d] got %b want %b", k, bus.req_ready, s[k].r);
      end
      if (k == 3) begin
        vectors++;
        if (bus.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL bubble_idle got valid=%b want 0", bus.out_valid);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bubble_beat[%0d] got unexpected src=%0d want none", k, bus.out_src);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.out_src, bus.out_data} !== exp) begin
            miscompares++;
            $display("FAIL bubble_beat[%0d] got src=%0d data=%h want src=%0d data=%h",
                     k, bus.out_src, bus.out_data, exp[W+1:W], exp[W-1:0]);
          end
        end
      end
      if (s[k].r != 4'b0000) exp_q.push_back(beat_of(s[k].r));
      step();
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bubble_end got valid=%b pending=%0d want 0/0", bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    step_t s [3];
    bus.req_valid = 4'b1111; bus.req_lock = 4'b0100; bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL rmid_start got %b want 0100", bus.req_ready);
    end
    exp_q.push_back(beat_of(4'b0100));
    step();
    bus.out_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0000 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_inrst got ready=%b valid=%b want 0000/1", bus.req_ready, bus.out_valid);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_flush got valid=%b want 0", bus.out_valid);
    end
    exp_q.delete();
    rst = 1'b0;
    s = '{'{4'b1110, 4'b0000, 1'b1, 4'b0010},
          '{4'b1110, 4'b0000, 1'b1, 4'b0100},
          '{4'b0000, 4'b0000, 1'b1, 4'b0000}};
    foreach (s[k]) begin
      bus.req_valid = s[k].v; bus.req_lock = s[k].l; bus.out_ready = s[k].o;
      #1;
      vectors++;
      if (bus.req_ready !== s[k].r) begin
        miscompares++;
        $display("FAIL rmid_ready[%0d] got %b want %b", k, bus.req_ready, s[k].r);
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rmid_beat[%0d] got unexpected src=%0d want none", k, bus.out_src);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.out_src, bus.out_data} !== exp) begin
            miscompares++;
            $display("FAIL rmid_beat[%0d] got src=%0d data=%h want src=%0d data=%h",
                     k, bus.out_src, bus.out_data, exp[W+1:W], exp[W-1:0]);
          end
        end
      end
      if (s[k].r != 4'b0000) exp_q.push_back(beat_of(s[k].r));
      step();
    end
    vectors++;
    if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rmid_end got valid=%b pending=%0d want 0/0", bus.out_valid, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_lock  = 4'b0000;
    bus.out_ready = 1'b0;
    bus.a_data    = 32'h0000_0003;
    bus.b_data    = 32'h0000_00ff;
    bus.c_data    = 32'h0000_000f;
    bus.d_data    = 32'h0000_00ee;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_lock_burst();
    test_forced_release();
    test_owner_bubble();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
